forw_hazard_unit: RTL and testbench
===================================

# forw_hazard_unit

Parametrised forwarding and hazard unit at the ID/EX boundary of the pipelined core. It tracks the destination registers of in-flight instructions across `NUM_STAGES` pipeline stages and selects operands per opcode class from the youngest matching stage. It raises a load-use stall, or a full RAW-hazard stall when forwarding is disabled. It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
- `XLEN`, 32: datapath width.
- `NUM_STAGES`, 3: tracked in-flight stages, ≥2. Stage 0 = EX/MEM, stage 1 = MEM/WB, higher = later writeback buffers.
- `CNT_W`, 16: stall counter width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `isForw_ON` in 1: 1 = forward; 0 = stall on every RAW hazard.
- `flush` in 1: squash all tracked in-flight instructions.
- `id_valid` in 1: instruction present in ID.
- `id_op` in 7: opcode of ID instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `data1`, `data2`, `s_data` in XLEN each: regfile rs1, immediate-or-rs2 operand, regfile rs2 for stores.
- `fwd_result` in NUM_STAGES*XLEN: result of stage k in bits [k*XLEN +: XLEN].
- `operand1`, `operand2`, `sData` out XLEN each: resolved operands (combinational).
- `stall` out 1: hold ID and PC; a bubble enters EX.
- `stall_cnt` out CNT_W: saturating count of stalled cycles.

## Operation
- Tracker: `NUM_STAGES` entries of {valid, rd, is_load}. A writer is any issued op except S_TYPE and B_TYPE with rd≠0. Entries with rd=0 are stored as invalid.
- Tracker advances every cycle. Entry k moves to k+1, and the oldest entry drops out.
- Entry 0 loads the ID instruction when `id_valid && !stall && !flush`. Otherwise entry 0 loads a bubble (valid=0).
- Source use by opcode class:
  - R_TYPE: rs1 and rs2.
  - I_IMM, I_LOAD, I_JALR: rs1 only.
  - S_TYPE: rs1 and rs2.
  - B_TYPE: rs1 and rs2, only with the macro (see Configuration).
  - LUI, AUIPC, JAL, unknown: none.
- Match: a source index ≠0 that equals a valid entry's rd. When several entries match, the lowest k (youngest) wins.
- Forwarding with `isForw_ON`=1:
  - rs1 match at stage k: `operand1` = result k; otherwise `data1`.
  - rs2 match, R_TYPE (and B_TYPE with macro): `operand2` = result k.
  - rs2 match, S_TYPE: `sData` = result k, while `operand2` stays `data2`.
  - All unmatched outputs pass `data1`/`data2`/`s_data` through.
- Load-use: a used source matching entry 0 with is_load=1 asserts `stall` for exactly one cycle. Next cycle the load sits in stage 1 and forwards normally.
- With `isForw_ON`=0:
  - `stall`=1 while any used source matches any valid entry.
  - Operands are pass-through only.
  - The regfile writes before it reads, so the stall clears once the writer leaves the last tracked stage.
- `stall` is 0 whenever `id_valid`=0 or `flush`=1.
- `flush`: every tracker entry is invalid on the next edge. A flush wins over a simultaneous issue or stall.
- `stall_cnt` increments on each cycle with `stall`=1 and saturates at all-ones. It never wraps.

## Timing
- Operands and `stall` are combinational from ID inputs, tracker state, `fwd_result` and `isForw_ON`. Zero-cycle latency.
- Tracker and `stall_cnt` update on the rising edge of `clk`.
- Upstream holds all `id_*` inputs stable while `stall`=1.
- Reset (`rst_n`=0 at an edge, including mid-operation):
  - All entries become invalid and `stall_cnt` becomes 0.
  - `stall`=0 and outputs are pass-through from the next cycle.
- Toggling `isForw_ON` takes effect in the same cycle. Tracker contents are kept.
- Load-use penalty is 1 cycle. With forwarding off, the worst case is NUM_STAGES stall cycles per dependency.

## Configuration
- `FWD_BRANCH_EN` defined:
  - B_TYPE rs1/rs2 are tracked sources and forward into `operand1`/`operand2`.
  - A B_TYPE following a load on the same register stalls one cycle.
- `FWD_BRANCH_EN` undefined:
  - B_TYPE is treated as using no sources.
  - Its operands are pass-through and it never stalls.

## Test plan
- R_TYPE x5 write, then R_TYPE reading rs1=x5 next cycle; `fwd_result[0]`=0x11, `data1`=0x0 -> `operand1`=0x11, `stall`=0.
- LOAD x7, then S_TYPE with rs2=x7 -> `stall`=1 for one cycle. Next cycle `sData`=`fwd_result[1]`=0xCAFE, `operand2`=`data2`, `stall_cnt`=1.
- Writes to x3 at stages 0 and 1 with results 0xA and 0xB, consumer rs1=x3 -> `operand1`=0xA (youngest wins). A consumer with rs1=x0 -> `operand1`=`data1`.
- `isForw_ON`=0, ADD x4 then ADD reading x4 with NUM_STAGES=3 -> `stall`=1 for 3 cycles, then the consumer issues with `operand1`=`data1`.
- LOAD x9 issued, then `flush`=1 together with a consumer of x9 -> `stall`=0 and the tracker is empty next cycle. Reset with `rst_n`=0 while stalled -> `stall`=0 and `stall_cnt`=0.
- Drive `stall` for 2^CNT_W+5 cycles -> `stall_cnt`=all-ones, no wrap. With `FWD_BRANCH_EN` undefined, B_TYPE after a LOAD to the same register -> `stall`=0.

Source files
------------

// File: rtl/forw_hazard_unit.sv
// Forwarding and hazard unit at the ID/EX boundary: in-flight destination tracker,
// operand forwarding, load-use / RAW stall and a saturating stall counter.
// Optional macro FWD_BRANCH_EN makes branches forwarding-aware sources.
module forw_hazard_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       isForw_ON,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic [6:0]                 id_op,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic [4:0]                 id_rd,
    input  logic [XLEN-1:0]            data1,
    input  logic [XLEN-1:0]            data2,
    input  logic [XLEN-1:0]            s_data,
    input  logic [NUM_STAGES*XLEN-1:0] fwd_result,
    output logic [XLEN-1:0]            operand1,
    output logic [XLEN-1:0]            operand2,
    output logic [XLEN-1:0]            sData,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

`ifdef FWD_BRANCH_EN
    localparam logic BR_EN = 1'b1;
`else
    localparam logic BR_EN = 1'b0;
`endif

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } trk_t;

    trk_t trk_q [NUM_STAGES];

    logic op_r, op_imm, op_load, op_jalr, op_s, op_b;
    logic use1, use2, writer;
    logic [NUM_STAGES-1:0] m1, m2;
    logic hit1, hit2;
    logic load_use, raw_any, issue;

    // Opcode class decode and source usage
    always_comb begin
        op_r    = (id_op == OP_R);
        op_imm  = (id_op == OP_IMM);
        op_load = (id_op == OP_LOAD);
        op_jalr = (id_op == OP_JALR);
        op_s    = (id_op == OP_STORE);
        op_b    = (id_op == OP_BR);
        use1    = op_r | op_imm | op_load | op_jalr | op_s | (op_b & BR_EN);
        use2    = op_r | op_s | (op_b & BR_EN);
        writer  = !(op_s || op_b) && (id_rd != '0);
    end

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            m1[i] = use1 && (id_rs1 != '0) && trk_q[i].valid && (trk_q[i].rd == id_rs1);
            m2[i] = use2 && (id_rs2 != '0) && trk_q[i].valid && (trk_q[i].rd == id_rs2);
        end
    end

    // Ascending scan so the youngest matching stage is taken first
    always_comb begin
        operand1 = data1;
        operand2 = data2;
        sData    = s_data;
        hit1     = 1'b0;
        hit2     = 1'b0;
        if (isForw_ON) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (m1[i] && !hit1) begin
                    hit1     = 1'b1;
                    operand1 = fwd_result[i*XLEN +: XLEN];
                end
                if (m2[i] && !hit2) begin
                    hit2 = 1'b1;
                    if (op_s) sData    = fwd_result[i*XLEN +: XLEN];
                    else      operand2 = fwd_result[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        load_use = (m1[0] | m2[0]) & trk_q[0].is_load;
        raw_any  = (|m1) | (|m2);
        stall    = id_valid && !flush && (isForw_ON ? load_use : raw_any);
        issue    = id_valid && !stall;
    end

    // In-flight tracker: shifts every cycle, bubble when nothing issues
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) trk_q[k] <= '0;
        end else begin
            trk_q[0] <= issue ? '{valid: writer, rd: id_rd, is_load: op_load} : '0;
            for (int unsigned k = 1; k < NUM_STAGES; k++) trk_q[k] <= trk_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_forw_hazard_unit.sv
// Directed self-checking bench for forw_hazard_unit (NUM_STAGES=3, CNT_W=4).
module tb_forw_hazard_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NS   = 3;
    localparam int unsigned CW   = 4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n, isForw_ON, flush, id_valid;
    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] data1, data2, s_data;
    logic [NS*XLEN-1:0] fwd_result;
    logic [XLEN-1:0] operand1, operand2, sData;
    logic stall;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    forw_hazard_unit #(.XLEN(XLEN), .NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .isForw_ON(isForw_ON), .flush(flush),
        .id_valid(id_valid), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .data1(data1), .data2(data2), .s_data(s_data),
        .fwd_result(fwd_result), .operand1(operand1), .operand2(operand2),
        .sData(sData), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        id_valid = 1'b1;
        id_op    = op;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_op    = 7'd0;
        id_rs1   = 5'd0;
        id_rs2   = 5'd0;
        id_rd    = 5'd0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; isForw_ON = 1'b1; flush = 1'b0;
        data1 = 32'h1111_0001; data2 = 32'h2222_0002; s_data = 32'h3333_0003;
        fwd_result = {32'hC0, 32'hB0, 32'hA0};
        idle();
        tick(); tick();
        rst_n = 1'b1;

        // Reset state: empty tracker, pass-through
        issue(OP_R, 5'd5, 5'd6, 5'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_op1", operand1, 32'h1111_0001);

        // R x5 then consumer of x5 forwards from stage 0
        issue(OP_R, 5'd1, 5'd2, 5'd5);
        check("wr_x5_stall", 32'(stall), 32'd0);
        tick();
        data1 = 32'h0; fwd_result = {32'hC0, 32'hB0, 32'h11};
        issue(OP_R, 5'd5, 5'd6, 5'd8);
        check("fwd_op1", operand1, 32'h11);
        check("fwd_op2_pass", operand2, 32'h2222_0002);
        check("fwd_stall", 32'(stall), 32'd0);
        tick();

        // Load x7 then store of x7: one-cycle load-use stall, then sData from stage 1
        issue(OP_LD, 5'd0, 5'd0, 5'd7);
        tick();
        data1 = 32'h1111_0001; data2 = 32'h22;
        issue(OP_S, 5'd1, 5'd7, 5'd0);
        check("lu_stall", 32'(stall), 32'd1);
        tick();
        fwd_result = {32'hC0, 32'hCAFE, 32'hA0};
        #1;
        check("lu_clear", 32'(stall), 32'd0);
        check("lu_sdata", sData, 32'hCAFE);
        check("lu_op2", operand2, 32'h22);
        check("lu_op1", operand1, 32'h1111_0001);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Two writers of x3: youngest (stage 0) wins
        issue(OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        issue(OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        fwd_result = {32'hC, 32'hB, 32'hA};
        issue(OP_R, 5'd3, 5'd0, 5'd0);
        check("young_op1", operand1, 32'hA);
        issue(OP_R, 5'd0, 5'd3, 5'd0);
        check("x0_op1", operand1, 32'h1111_0001);
        check("young_op2", operand2, 32'hA);
        idle();
        tick(); tick(); tick();

        // Forwarding off: RAW stall lasts NUM_STAGES cycles
        isForw_ON = 1'b0;
        issue(OP_R, 5'd1, 5'd2, 5'd4);
        tick();
        data1 = 32'h55; fwd_result = {32'hC0, 32'hB0, 32'h99};
        issue(OP_R, 5'd4, 5'd0, 5'd0);
        check("raw_stall_c1", 32'(stall), 32'd1);
        check("raw_op1_pass", operand1, 32'h55);
        tick();
        check("raw_stall_c2", 32'(stall), 32'd1);
        tick();
        check("raw_stall_c3", 32'(stall), 32'd1);
        tick();
        check("raw_clear", 32'(stall), 32'd0);
        check("raw_op1", operand1, 32'h55);
        check("raw_cnt", 32'(stall_cnt), 32'd4);
        tick();
        isForw_ON = 1'b1;

        // Flush beats a load-use stall and empties the tracker
        issue(OP_LD, 5'd0, 5'd0, 5'd9);
        tick();
        flush = 1'b1;
        issue(OP_R, 5'd9, 5'd0, 5'd0);
        check("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        fwd_result = {32'hC0, 32'hB0, 32'hA0};
        #1;
        check("flush_empty_stall", 32'(stall), 32'd0);
        check("flush_empty_op1", operand1, 32'h55);
        check("flush_cnt", 32'(stall_cnt), 32'd4);
        idle();
        tick();

        // Reset while stalled
        issue(OP_LD, 5'd0, 5'd0, 5'd9);
        tick();
        issue(OP_R, 5'd9, 5'd0, 5'd0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        idle();
        tick();

        // Saturating counter: 21 load-use stalls into a 4-bit counter
        for (int i = 1; i <= 21; i++) begin
            issue(OP_LD, 5'd0, 5'd0, 5'd9);
            tick();
            issue(OP_R, 5'd9, 5'd0, 5'd0);
            tick();
            tick();
            if (i == 14) check("cnt_14", 32'(stall_cnt), 32'd14);
            if (i == 15) check("cnt_15", 32'(stall_cnt), 32'd15);
        end
        check("cnt_sat", 32'(stall_cnt), 32'd15);

        // Branch after load on same register: no stall, pass-through
        issue(OP_LD, 5'd0, 5'd0, 5'd9);
        tick();
        fwd_result = {32'hC0, 32'hB0, 32'hA0};
        issue(OP_B, 5'd9, 5'd9, 5'd0);
        check("br_stall", 32'(stall), 32'd0);
        check("br_op1", operand1, 32'h55);
        check("br_op2", operand2, 32'h22);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
